// File: rtl/alu_issue_stage.sv
// alu_issue_stage: two-stage EX/WB issue pipeline in front of a shared
// combinational ALU.
//
// EX stage: decodes a MIPS instruction into operands A/B and a 4-bit ALU
// control code, and registers them on input transfer. The ALU evaluates them
// combinationally and hands ALU_RESULT back. WB stage: ALU_RESULT is captured
// with its destination index and held until the consumer takes it.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   IN_VALID/IN_READY input handshake for INSTR, RS_DATA, RT_DATA
//   ALU_A/ALU_B       registered operands to the shared ALU
//   ALU_OP_OUT        registered ALU control code
//   ALU_RESULT        combinational ALU output for the current A/B/OP
//   WB_VALID/WB_READY output handshake for WB_DATA, WB_REG
//   ILLEGAL           one-cycle pulse after an unsupported instruction is taken
module alu_issue_stage #(
  parameter int DATA_W         = 32,
  parameter bit EMIT_ZERO_DEST = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [31:0]       INSTR,
  input  logic [DATA_W-1:0] RS_DATA,
  input  logic [DATA_W-1:0] RT_DATA,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic [3:0]        ALU_OP_OUT,
  input  logic [DATA_W-1:0] ALU_RESULT,
  output logic              WB_VALID,
  input  logic              WB_READY,
  output logic [DATA_W-1:0] WB_DATA,
  output logic [4:0]        WB_REG,
  output logic              ILLEGAL
);

  localparam logic [3:0] OP_SLL = 4'b0000;
  localparam logic [3:0] OP_SRL = 4'b0010;
  localparam logic [3:0] OP_SRA = 4'b0011;
  localparam logic [3:0] OP_SLT = 4'b0101;
  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_SUB = 4'b1010;
  localparam logic [3:0] OP_AND = 4'b1100;
  localparam logic [3:0] OP_OR  = 4'b1101;
  localparam logic [3:0] OP_NOR = 4'b1111;

  // Instruction fields. The rs field itself is not needed: its value
  // arrives already read on RS_DATA.
  logic [5:0]  opcode, funct;
  logic [4:0]  rt, rd, shamt;
  logic [15:0] imm;
  logic        unused_rs;

  assign opcode    = INSTR[31:26];
  assign rt        = INSTR[20:16];
  assign rd        = INSTR[15:11];
  assign shamt     = INSTR[10:6];
  assign funct     = INSTR[5:0];
  assign imm       = INSTR[15:0];
  assign unused_rs = ^INSTR[25:21];

  // Pipeline state
  logic       ex_valid;
  logic [4:0] ex_dest;
  logic       wb_free, in_fire;

  assign wb_free  = !WB_VALID || WB_READY;
  assign IN_READY = !ex_valid || wb_free;
  assign in_fire  = IN_VALID && IN_READY;

  // Decode
  logic [DATA_W-1:0] dec_a, dec_b, simm, zimm;
  logic [3:0]        dec_op;
  logic [4:0]        dec_dest;
  logic              dec_legal, dec_emit;

  assign simm = {{(DATA_W-16){imm[15]}}, imm};
  assign zimm = {{(DATA_W-16){1'b0}}, imm};

  always_comb begin
    dec_a     = RS_DATA;
    dec_b     = RT_DATA;
    dec_op    = OP_SLL;
    dec_dest  = 5'd0;
    dec_legal = 1'b0;
    case (opcode)
      6'h00: begin
        dec_dest  = rd;
        dec_legal = 1'b1;
        case (funct)
          6'h00:        begin dec_op = OP_SLL; dec_a = {{(DATA_W-5){1'b0}}, shamt}; end
          6'h02:        begin dec_op = OP_SRL; dec_a = {{(DATA_W-5){1'b0}}, shamt}; end
          6'h03:        begin dec_op = OP_SRA; dec_a = {{(DATA_W-5){1'b0}}, shamt}; end
          6'h04:        dec_op = OP_SLL;
          6'h06:        dec_op = OP_SRL;
          6'h07:        dec_op = OP_SRA;
          6'h20, 6'h21: dec_op = OP_ADD;  // no overflow trap: add behaves as addu
          6'h22, 6'h23: dec_op = OP_SUB;
          6'h24:        dec_op = OP_AND;
          6'h25:        dec_op = OP_OR;
          6'h27:        dec_op = OP_NOR;
          6'h2A:        dec_op = OP_SLT;
          default:      dec_legal = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin dec_dest = rt; dec_legal = 1'b1; dec_op = OP_ADD; dec_b = simm; end
      6'h0A:        begin dec_dest = rt; dec_legal = 1'b1; dec_op = OP_SLT; dec_b = simm; end
      6'h0C:        begin dec_dest = rt; dec_legal = 1'b1; dec_op = OP_AND; dec_b = zimm; end
      6'h0D:        begin dec_dest = rt; dec_legal = 1'b1; dec_op = OP_OR;  dec_b = zimm; end
      default:      dec_legal = 1'b0;
    endcase
  end

  // Illegal and $0-targeting instructions still occupy the ALU operand
  // registers, but never mark EX valid, so they vanish as bubbles.
  assign dec_emit = dec_legal && (EMIT_ZERO_DEST || (dec_dest != 5'd0));

  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_valid   <= 1'b0;
      ex_dest    <= 5'd0;
      ALU_A      <= '0;
      ALU_B      <= '0;
      ALU_OP_OUT <= 4'b0000;
      WB_VALID   <= 1'b0;
      WB_DATA    <= '0;
      WB_REG     <= 5'd0;
      ILLEGAL    <= 1'b0;
    end else begin
      // Operands change only on input transfer, so the ALU result stays
      // valid for the whole time EX is stalled behind a full WB.
      if (in_fire) begin
        ALU_A      <= dec_a;
        ALU_B      <= dec_b;
        ALU_OP_OUT <= dec_op;
        ex_dest    <= dec_dest;
        ex_valid   <= dec_emit;
      end else if (wb_free) begin
        ex_valid <= 1'b0;
      end

      ILLEGAL <= in_fire && !dec_legal;

      // Consume and refill in the same cycle keeps WB full with no bubble.
      if (ex_valid && wb_free) begin
        WB_VALID <= 1'b1;
        WB_DATA  <= ALU_RESULT;
        WB_REG   <= ex_dest;
      end else if (WB_READY) begin
        WB_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID, IN_READY;
  logic [31:0] INSTR, RS_DATA, RT_DATA;
  logic [31:0] ALU_A, ALU_B, ALU_RESULT;
  logic [3:0]  ALU_OP_OUT;
  logic        WB_VALID, WB_READY;
  logic [31:0] WB_DATA;
  logic [4:0]  WB_REG;
  logic        ILLEGAL;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  dst;
  } wb_t;
  wb_t exp_q[$];

  always #5 CLK = ~CLK;

  alu_issue_stage dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .INSTR(INSTR), .RS_DATA(RS_DATA), .RT_DATA(RT_DATA),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OP_OUT(ALU_OP_OUT),
    .ALU_RESULT(ALU_RESULT),
    .WB_VALID(WB_VALID), .WB_READY(WB_READY),
    .WB_DATA(WB_DATA), .WB_REG(WB_REG), .ILLEGAL(ILLEGAL)
  );

  // Shared combinational ALU driven by the stage's control code.
  always_comb begin
    case (ALU_OP_OUT)
      4'b0000: ALU_RESULT = ALU_B << ALU_A[4:0];
      4'b0010: ALU_RESULT = ALU_B >> ALU_A[4:0];
      4'b0011: ALU_RESULT = $unsigned($signed(ALU_B) >>> ALU_A[4:0]);
      4'b0101: ALU_RESULT = ($signed(ALU_A) < $signed(ALU_B)) ? 32'd1 : 32'd0;
      4'b1000: ALU_RESULT = ALU_A + ALU_B;
      4'b1010: ALU_RESULT = ALU_A - ALU_B;
      4'b1100: ALU_RESULT = ALU_A & ALU_B;
      4'b1101: ALU_RESULT = ALU_A | ALU_B;
      4'b1111: ALU_RESULT = ~(ALU_A | ALU_B);
      default: ALU_RESULT = 32'hDEADBEEF;
    endcase
  end

  // Architectural reference: what the instruction writes to which register.
  function automatic void ref_model(input logic [31:0] ins, input logic [31:0] rs,
                                    input logic [31:0] rt, output logic [31:0] d,
                                    output logic [4:0] dst, output bit legal);
    logic [31:0] se, ze;
    logic [4:0]  sh;
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'd0, ins[15:0]};
    sh = ins[10:6];
    legal = 1'b1;
    d = 32'd0;
    dst = (ins[31:26] == 6'h00) ? ins[15:11] : ins[20:16];
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h00: d = rt << sh;
        6'h02: d = rt >> sh;
        6'h03: d = $unsigned($signed(rt) >>> sh);
        6'h04: d = rt << rs[4:0];
        6'h06: d = rt >> rs[4:0];
        6'h07: d = $unsigned($signed(rt) >>> rs[4:0]);
        6'h20, 6'h21: d = rs + rt;
        6'h22, 6'h23: d = rs - rt;
        6'h24: d = rs & rt;
        6'h25: d = rs | rt;
        6'h27: d = ~(rs | rt);
        6'h2A: d = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
        default: legal = 1'b0;
      endcase
      6'h08, 6'h09: d = rs + se;
      6'h0A: d = ($signed(rs) < $signed(se)) ? 32'd1 : 32'd0;
      6'h0C: d = rs & ze;
      6'h0D: d = rs | ze;
      default: legal = 1'b0;
    endcase
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      IN_VALID = 1'b0;
      WB_READY = 1'b1;
    end
  endtask

  task automatic test_reset;
    RST = 1'b1; IN_VALID = 1'b0; WB_READY = 1'b1;
    INSTR = '0; RS_DATA = '0; RT_DATA = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    checks++;
    if (WB_VALID !== 1'b0 || ALU_A !== 32'd0 || ALU_B !== 32'd0 || ALU_OP_OUT !== 4'b0000 ||
        WB_DATA !== 32'd0 || WB_REG !== 5'd0 || ILLEGAL !== 1'b0 || IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: wbv=%b a=%h b=%h op=%b d=%h r=%0d ill=%b rdy=%b, want all zero and rdy=1",
               WB_VALID, ALU_A, ALU_B, ALU_OP_OUT, WB_DATA, WB_REG, ILLEGAL, IN_READY);
    end
  endtask

  task automatic test_add;
    @(negedge CLK);
    IN_VALID = 1'b1; INSTR = 32'h00221820; RS_DATA = 32'd5; RT_DATA = 32'd7; WB_READY = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    #1;
    checks++;
    if (ALU_A !== 32'd5 || ALU_B !== 32'd7 || ALU_OP_OUT !== 4'b1000 || WB_VALID !== 1'b0) begin
      errors++;
      $display("FAIL add_operands: a=%0d b=%0d op=%b wbv=%b, want 5 7 1000 0", ALU_A, ALU_B, ALU_OP_OUT, WB_VALID);
    end
    @(negedge CLK);
    #1;
    checks++;
    if (WB_VALID !== 1'b1 || WB_DATA !== 32'd12 || WB_REG !== 5'd3) begin
      errors++;
      $display("FAIL add_wb: v=%b d=%0d r=%0d, want 1 12 3", WB_VALID, WB_DATA, WB_REG);
    end
    idle(2);
  endtask

  task automatic test_sll;
    @(negedge CLK);
    IN_VALID = 1'b1; INSTR = 32'h00011100; RS_DATA = 32'h0; RT_DATA = 32'h3;
    @(negedge CLK);
    IN_VALID = 1'b0;
    #1;
    checks++;
    if (ALU_A !== 32'd4 || ALU_B !== 32'd3 || ALU_OP_OUT !== 4'b0000) begin
      errors++;
      $display("FAIL sll_operands: a=%0d b=%0d op=%b, want 4 3 0000", ALU_A, ALU_B, ALU_OP_OUT);
    end
    @(negedge CLK);
    #1;
    checks++;
    if (WB_VALID !== 1'b1 || WB_DATA !== 32'h30 || WB_REG !== 5'd2) begin
      errors++;
      $display("FAIL sll_wb: v=%b d=%h r=%0d, want 1 30 2", WB_VALID, WB_DATA, WB_REG);
    end
    idle(2);
  endtask

  task automatic test_imm;
    logic [31:0] ins [2] = '{32'h2004FFFF, 32'h34058000};
    logic [31:0] eb  [2] = '{32'hFFFFFFFF, 32'h00008000};
    logic [3:0]  eop [2] = '{4'b1000, 4'b1101};
    logic [31:0] ed  [2] = '{32'hFFFFFFFF, 32'h00008000};
    logic [4:0]  er  [2] = '{5'd4, 5'd5};
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      IN_VALID = 1'b1; INSTR = ins[k]; RS_DATA = 32'd0; RT_DATA = 32'h12345678;
      @(negedge CLK);
      IN_VALID = 1'b0;
      #1;
      checks++;
      if (ALU_A !== 32'd0 || ALU_B !== eb[k] || ALU_OP_OUT !== eop[k]) begin
        errors++;
        $display("FAIL imm%0d_operands: a=%h b=%h op=%b, want 0 %h %b", k, ALU_A, ALU_B, ALU_OP_OUT, eb[k], eop[k]);
      end
      @(negedge CLK);
      #1;
      checks++;
      if (WB_VALID !== 1'b1 || WB_DATA !== ed[k] || WB_REG !== er[k]) begin
        errors++;
        $display("FAIL imm%0d_wb: v=%b d=%h r=%0d, want 1 %h %0d", k, WB_VALID, WB_DATA, WB_REG, ed[k], er[k]);
      end
      idle(2);
    end
  endtask

  task automatic test_drops;
    logic [31:0] ins [2] = '{32'hFC000000, 32'h00000000};
    logic        eill[2] = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      IN_VALID = 1'b1; INSTR = ins[k]; RS_DATA = 32'd9; RT_DATA = 32'd9;
      @(negedge CLK);
      IN_VALID = 1'b0;
      #1;
      checks++;
      if (ILLEGAL !== eill[k] || WB_VALID !== 1'b0) begin
        errors++;
        $display("FAIL drop%0d_first: ill=%b wbv=%b, want %b 0", k, ILLEGAL, WB_VALID, eill[k]);
      end
      for (int c = 0; c < 3; c++) begin
        @(negedge CLK);
        #1;
        checks++;
        if (ILLEGAL !== 1'b0 || WB_VALID !== 1'b0) begin
          errors++;
          $display("FAIL drop%0d_after%0d: ill=%b wbv=%b, want 0 0", k, c, ILLEGAL, WB_VALID);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int n = 0;
    logic [31:0] exp_d [4];
    for (int i = 0; i < 4; i++) exp_d[i] = (32'd100 * i + 1) + (32'd3 * i + 2);
    for (int c = 0; c < 7; c++) begin
      @(negedge CLK);
      WB_READY = (c >= 3);
      IN_VALID = (n < 4);
      INSTR    = {6'h00, 5'd1, 5'd2, 5'(n + 1), 5'd0, 6'h20};
      RS_DATA  = 32'd100 * n + 1;
      RT_DATA  = 32'd3 * n + 2;
      #1;
      if (c == 2) begin
        checks++;
        if (IN_READY !== 1'b0 || n != 2 || ALU_A !== 32'd101 || ALU_B !== 32'd5 || WB_DATA !== exp_d[0]) begin
          errors++;
          $display("FAIL bp_stall: rdy=%b accepted=%0d a=%0d b=%0d wbd=%0d, want 0 2 101 5 %0d",
                   IN_READY, n, ALU_A, ALU_B, WB_DATA, exp_d[0]);
        end
      end
      if (c >= 3) begin
        checks++;
        if (WB_VALID !== 1'b1 || WB_DATA !== exp_d[c-3] || WB_REG !== 5'(c - 2)) begin
          errors++;
          $display("FAIL bp_drain%0d: v=%b d=%0d r=%0d, want 1 %0d %0d", c - 3, WB_VALID, WB_DATA, WB_REG, exp_d[c-3], c - 2);
        end
      end
      if (IN_VALID && IN_READY) n++;
    end
    idle(3);
  endtask

  task automatic test_reset_midflight;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      WB_READY = 1'b0; IN_VALID = 1'b1;
      INSTR = {6'h00, 5'd1, 5'd2, 5'(c + 7), 5'd0, 6'h21};
      RS_DATA = 32'd40 + c; RT_DATA = 32'd1;
    end
    @(negedge CLK);
    IN_VALID = 1'b0; RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checks++;
    if (WB_VALID !== 1'b0 || ALU_OP_OUT !== 4'b0000 || IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: wbv=%b op=%b rdy=%b, want 0 0000 1", WB_VALID, ALU_OP_OUT, IN_READY);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      WB_READY = 1'b1;
      #1;
      checks++;
      if (WB_VALID !== 1'b0) begin
        errors++;
        $display("FAIL rst_stale%0d: wbv=%b, want 0", c, WB_VALID);
      end
    end
  endtask

  task automatic test_random;
    logic [5:0] rfun [14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20,
                              6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A};
    logic [5:0] iop  [5]  = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D};
    bit          pending = 0;
    bit          exp_ill = 0;
    logic [31:0] d;
    logic [4:0]  dst;
    bit          legal;
    int          kind;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge CLK);
      if (!pending) begin
        IN_VALID = ($urandom_range(0, 3) != 0);
        kind = $urandom_range(0, 19);
        RS_DATA = $urandom;
        RT_DATA = $urandom;
        if (kind == 0)
          INSTR = {6'h3F, 26'($urandom)};
        else if (kind == 1)
          INSTR = {6'h00, 20'($urandom), 6'h01};
        else if (kind < 12)
          INSTR = {6'h00, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom), rfun[$urandom_range(0, 13)]};
        else
          INSTR = {iop[$urandom_range(0, 4)], 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 16'($urandom)};
      end
      WB_READY = (cyc < 1480) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (cyc >= 1480) IN_VALID = pending;
      #1;
      checks++;
      if (ILLEGAL !== exp_ill) begin
        errors++;
        $display("FAIL rand_illegal cyc=%0d: ill=%b, want %b", cyc, ILLEGAL, exp_ill);
      end
      exp_ill = 0;
      if (WB_VALID && WB_READY) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_wb cyc=%0d: unexpected d=%h r=%0d, want no entry", cyc, WB_DATA, WB_REG);
        end else begin
          if (WB_DATA !== exp_q[0].data || WB_REG !== exp_q[0].dst) begin
            errors++;
            $display("FAIL rand_wb cyc=%0d: d=%h r=%0d, want %h %0d", cyc, WB_DATA, WB_REG, exp_q[0].data, exp_q[0].dst);
          end
          void'(exp_q.pop_front());
        end
      end
      if (IN_VALID && IN_READY) begin
        ref_model(INSTR, RS_DATA, RT_DATA, d, dst, legal);
        if (legal && dst != 5'd0) exp_q.push_back('{data: d, dst: dst});
        exp_ill = !legal;
        pending = 0;
      end else begin
        pending = IN_VALID;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: %0d results outstanding, want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sll();
    test_imm();
    test_drops();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
